cadc_alu_job_scheduler: RTL and testbench

- Two-requester round-robin scheduler that shares the 20-bit register/ALU datapath between computation channels (e.g. air-data channel 0 and 1).
- Accepts jobs {op, A, B} over valid/ready.
- Sequences the datapath's address-decoded load bus: addr 1 = regA, addr 2 = regB, addr 0 = opcode.
- Waits a fixed ALU latency, captures the datapath result and returns it tagged with the requester ID.

---
 rtl/cadc_alu_job_scheduler.sv | 148 ++++++++++++++
 tb/tb_cadc_alu_job_scheduler.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cadc_alu_job_scheduler.sv
// rtl/cadc_alu_job_scheduler.sv - two-channel round-robin job scheduler for the shared 20-bit ALU datapath
module cadc_alu_job_scheduler #(
   parameter int DATA_W  = 20,
   parameter int ALU_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [2:0]        req0_op,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [2:0]        req1_op,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   output logic [DATA_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_data,
   output logic              bus_we,
   input  logic [DATA_W-1:0] alu_result,
   output logic              rsp_valid,
   output logic              rsp_id,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err,
   output logic              busy
);

   localparam int CNT_W = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD_A,
      ST_LOAD_B,
      ST_LOAD_OP,
      ST_WAIT
   } state_t;

   state_t            state;
   logic              prio;
   logic [CNT_W-1:0]  cnt;
   logic [2:0]        job_op;
   logic [DATA_W-1:0] job_b;
   logic              job_id;

   logic              grant0;
   logic              grant1;
   logic              accept;
   logic              acc_id;
   logic [2:0]        acc_op;
   logic [DATA_W-1:0] acc_a;
   logic [DATA_W-1:0] acc_b;

   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (state == ST_IDLE && !rst) begin
         if (req0_valid && req1_valid) begin
            grant0 = ~prio;
            grant1 = prio;
         end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
         end
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign accept     = grant0 | grant1;
   assign acc_id     = grant1;
   assign acc_op     = grant1 ? req1_op : req0_op;
   assign acc_a      = grant1 ? req1_a  : req0_a;
   assign acc_b      = grant1 ? req1_b  : req0_b;
   assign busy       = (state != ST_IDLE);

   // Operand A goes straight onto the bus at accept; bus_data is its only latch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         prio      <= 1'b0;
         cnt       <= '0;
         job_op    <= '0;
         job_b     <= '0;
         job_id    <= 1'b0;
         bus_addr  <= '0;
         bus_data  <= '0;
         bus_we    <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_id    <= 1'b0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  job_op <= acc_op;
                  job_b  <= acc_b;
                  job_id <= acc_id;
                  prio   <= ~acc_id;
                  if (acc_op[2]) begin
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_data  <= '0;
                     rsp_id    <= acc_id;
                  end else begin
                     state    <= ST_LOAD_A;
                     bus_we   <= 1'b1;
                     bus_addr <= DATA_W'(1);
                     bus_data <= acc_a;
                  end
               end
            end
            ST_LOAD_A: begin
               state    <= ST_LOAD_B;
               bus_addr <= DATA_W'(2);
               bus_data <= job_b;
            end
            ST_LOAD_B: begin
               state    <= ST_LOAD_OP;
               bus_addr <= '0;
               bus_data <= {{(DATA_W-3){1'b0}}, job_op};
            end
            ST_LOAD_OP: begin
               state  <= ST_WAIT;
               bus_we <= 1'b0;
               cnt    <= CNT_W'(ALU_LAT);
            end
            // Address stays 0 here so the datapath keeps its opcode.
            ST_WAIT: begin
               if (cnt == CNT_W'(1)) begin
                  state     <= ST_IDLE;
                  bus_addr  <= '0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  rsp_data  <= alu_result;
                  rsp_id    <= job_id;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cadc_alu_job_scheduler.sv
// tb/tb_cadc_alu_job_scheduler.sv - randomized bench for the ALU job scheduler, ALU_LAT=2 and ALU_LAT=1 builds
module tb_cadc_alu_job_scheduler;

   logic clk;
   logic rst;
   logic req0_valid, req1_valid;
   logic [2:0] req0_op, req1_op;
   logic [19:0] req0_a, req0_b, req1_a, req1_b;

   logic [1:0] r0_rdy, r1_rdy, b_we, r_valid, r_id, r_err, bsy;
   logic [1:0][19:0] b_addr, b_data, alu_res, r_data;

   int n_checks = 0;
   int n_err = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   cadc_alu_job_scheduler #(.DATA_W(20), .ALU_LAT(2)) u_dut0 (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(r0_rdy[0]), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(r1_rdy[0]), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
      .bus_addr(b_addr[0]), .bus_data(b_data[0]), .bus_we(b_we[0]), .alu_result(alu_res[0]),
      .rsp_valid(r_valid[0]), .rsp_id(r_id[0]), .rsp_data(r_data[0]), .rsp_err(r_err[0]), .busy(bsy[0])
   );

   cadc_alu_job_scheduler #(.DATA_W(20), .ALU_LAT(1)) u_dut1 (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(r0_rdy[1]), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(r1_rdy[1]), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
      .bus_addr(b_addr[1]), .bus_data(b_data[1]), .bus_we(b_we[1]), .alu_result(alu_res[1]),
      .rsp_valid(r_valid[1]), .rsp_id(r_id[1]), .rsp_data(r_data[1]), .rsp_err(r_err[1]), .busy(bsy[1])
   );

   function automatic logic [19:0] op_fn(input logic [2:0] op, input logic [19:0] a, input logic [19:0] b);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         default: return a | b;
      endcase
   endfunction

   // Datapath model: a non-zero address drops the opcode; result is poisoned until a full reload.
   logic [1:0][19:0] dp_a, dp_b, dp_hist, dp_f;
   logic [1:0][2:0]  dp_op;
   logic [1:0]       dp_ok;

   assign dp_f[0] = dp_ok[0] ? op_fn(dp_op[0], dp_a[0], dp_b[0]) : 20'h5A5A5;
   assign dp_f[1] = dp_ok[1] ? op_fn(dp_op[1], dp_a[1], dp_b[1]) : 20'h5A5A5;
   assign alu_res[0] = dp_hist[0];
   assign alu_res[1] = dp_f[1];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         dp_a <= '0; dp_b <= '0; dp_hist <= '0; dp_op <= '0; dp_ok <= '0;
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (b_we[k] && b_addr[k] == 20'd0) begin
               dp_op[k] <= b_data[k][2:0];
               dp_ok[k] <= 1'b1;
            end else if (b_addr[k] != 20'd0) begin
               dp_ok[k] <= 1'b0;
            end
            if (b_we[k] && b_addr[k] == 20'd1) dp_a[k] <= b_data[k];
            if (b_we[k] && b_addr[k] == 20'd2) dp_b[k] <= b_data[k];
            dp_hist[k] <= dp_f[k];
         end
      end
   end

   // Reference model state, one slot per build.
   int          cyc;
   int          lat [2] = '{2, 1};
   int          free_at [2];
   bit          prio_m [2];
   bit          pend_v [2];
   int          pend_c [2];
   bit          pend_id [2];
   bit          pend_e [2];
   logic [19:0] pend_d [2];
   bit          h_id [2];
   bit          h_err [2];
   logic [19:0] h_data [2];
   int          lj_c [2];
   logic [19:0] lj_a [2];
   logic [19:0] lj_b [2];
   logic [2:0]  lj_op [2];

   bit          rec;
   int          gcount;
   logic [5:0]  gbits;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic string tg(input string s, input int k);
      return $sformatf("u%0d.%s", k, s);
   endfunction

   task automatic reset_model();
      for (int k = 0; k < 2; k++) begin
         free_at[k] = 0; prio_m[k] = 0; pend_v[k] = 0;
         h_id[k] = 0; h_err[k] = 0; h_data[k] = '0;
         lj_c[k] = -1000; lj_a[k] = '0; lj_b[k] = '0; lj_op[k] = '0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk(tg("rst_ready0", k), 32'(r0_rdy[k]), 32'd0);
         chk(tg("rst_ready1", k), 32'(r1_rdy[k]), 32'd0);
         chk(tg("rst_bus_we", k), 32'(b_we[k]), 32'd0);
         chk(tg("rst_bus_addr", k), 32'(b_addr[k]), 32'd0);
         chk(tg("rst_bus_data", k), 32'(b_data[k]), 32'd0);
         chk(tg("rst_rsp_valid", k), 32'(r_valid[k]), 32'd0);
         chk(tg("rst_rsp_id", k), 32'(r_id[k]), 32'd0);
         chk(tg("rst_rsp_data", k), 32'(r_data[k]), 32'd0);
         chk(tg("rst_rsp_err", k), 32'(r_err[k]), 32'd0);
         chk(tg("rst_busy", k), 32'(bsy[k]), 32'd0);
      end
      @(negedge clk);
      rst = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      reset_model();
      @(posedge clk);
      cyc++;
   endtask

   task automatic step(input logic v0, input logic [2:0] o0, input logic [19:0] a0, input logic [19:0] b0,
                       input logic v1, input logic [2:0] o1, input logic [19:0] a1, input logic [19:0] b1);
      int d;
      bit exp_v;
      bit gr;
      bit g;
      logic [2:0] op;
      logic [19:0] a, b;
      logic [19:0] data_e;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         exp_v = 0;
         if (pend_v[k] && pend_c[k] == cyc) begin
            exp_v = 1;
            pend_v[k] = 0;
            h_data[k] = pend_d[k];
            h_id[k] = pend_id[k];
            h_err[k] = pend_e[k];
         end
         chk(tg("rsp_valid", k), 32'(r_valid[k]), 32'(exp_v));
         chk(tg("rsp_data", k), 32'(r_data[k]), 32'(h_data[k]));
         chk(tg("rsp_id", k), 32'(r_id[k]), 32'(h_id[k]));
         chk(tg("rsp_err", k), 32'(r_err[k]), 32'(h_err[k]));
         chk(tg("busy", k), 32'(bsy[k]), 32'(cyc < free_at[k]));
         d = cyc - lj_c[k];
         data_e = (d == 1) ? lj_a[k] : (d == 2) ? lj_b[k] : {17'd0, lj_op[k]};
         chk(tg("bus_we", k), 32'(b_we[k]), 32'(d >= 1 && d <= 3));
         chk(tg("bus_addr", k), 32'(b_addr[k]), (d == 1) ? 32'd1 : (d == 2) ? 32'd2 : 32'd0);
         chk(tg("bus_data", k), 32'(b_data[k]), 32'(data_e));
      end
      req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
      req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         gr = 0;
         g = 0;
         if (cyc >= free_at[k]) begin
            if (v0 && v1) begin gr = 1; g = prio_m[k]; end
            else if (v0) begin gr = 1; g = 0; end
            else if (v1) begin gr = 1; g = 1; end
         end
         chk(tg("ready0", k), 32'(r0_rdy[k]), 32'(gr && !g));
         chk(tg("ready1", k), 32'(r1_rdy[k]), 32'(gr && g));
         if (k == 0 && rec && (r0_rdy[0] || r1_rdy[0])) begin
            gbits = {gbits[4:0], r1_rdy[0]};
            gcount++;
         end
         if (gr) begin
            op = g ? o1 : o0;
            a = g ? a1 : a0;
            b = g ? b1 : b0;
            prio_m[k] = !g;
            pend_v[k] = 1;
            pend_id[k] = g;
            if (op >= 3'd4) begin
               pend_c[k] = cyc + 1;
               pend_e[k] = 1;
               pend_d[k] = '0;
               free_at[k] = cyc + 1;
            end else begin
               pend_c[k] = cyc + 4 + lat[k];
               pend_e[k] = 0;
               pend_d[k] = op_fn(op, a, b);
               free_at[k] = cyc + 4 + lat[k];
               lj_c[k] = cyc; lj_a[k] = a; lj_b[k] = b; lj_op[k] = op;
            end
         end
      end
      @(posedge clk);
      cyc++;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 3'd0, 20'd0, 20'd0, 1'b0, 3'd0, 20'd0, 20'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
      req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
      cyc = 0;
      rec = 0; gcount = 0; gbits = '0;
      reset_model();
      do_reset();

      step(1'b1, 3'd0, 20'd5, 20'd3, 1'b0, 3'd0, 20'd0, 20'd0);
      idle(8);
      step(1'b0, 3'd0, 20'd0, 20'd0, 1'b1, 3'd1, 20'd3, 20'd5);
      idle(8);

      rec = 1;
      repeat (36) step(1'b1, 3'($urandom_range(0, 3)), 20'($urandom), 20'($urandom),
                       1'b1, 3'($urandom_range(0, 3)), 20'($urandom), 20'($urandom));
      rec = 0;
      chk("grant_count", 32'(gcount), 32'd6);
      chk("grant_order", 32'(gbits), 32'b010101);
      idle(8);

      step(1'b1, 3'd5, 20'($urandom), 20'($urandom), 1'b0, 3'd0, 20'd0, 20'd0);
      step(1'b1, 3'd0, 20'd7, 20'd9, 1'b0, 3'd0, 20'd0, 20'd0);
      idle(8);

      step(1'b1, 3'd0, 20'h11111, 20'h22222, 1'b0, 3'd0, 20'd0, 20'd0);
      idle(4);
      do_reset();
      idle(1);
      step(1'b1, 3'd3, 20'hF0F0F, 20'h0F0F0, 1'b0, 3'd0, 20'd0, 20'd0);
      idle(8);

      step(1'b0, 3'd0, 20'd0, 20'd0, 1'b1, 3'd2, 20'hFFFFF, 20'h12345);
      idle(8);

      repeat (400) step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 20'($urandom), 20'($urandom),
                        1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 20'($urandom), 20'($urandom));
      idle(10);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
